mx_int_block_quantiser: RTL and testbench

Streaming BF16 to MX-integer block quantiser, the parametrised successor of the single-shot combinational BF16 to MXINT8 converter. It accepts a block of K BF16 values as K/LANES beats over a valid/ready stream and buffers the whole block while tracking the shared exponent. It then emits K/LANES beats of WIDTH-bit two's-complement elements plus one E8M0 scale per block. It sits between the BF16 datapath and the MX packing/storage stage.

---
 rtl/mx_int_block_quantiser.sv | 150 +++++++++++++++
 tb/tb_mx_int_block_quantiser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mx_int_block_quantiser.sv
// Streaming BF16 -> MX-integer block quantiser.
// Buffers one K-element block, tracks the shared exponent, then drains WIDTH-bit elements plus an E8M0 scale.
module mx_int_block_quantiser #(
    parameter int WIDTH = 8,
    parameter int K     = 32,
    parameter int LANES = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [LANES-1:0][15:0]       i_bf16,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [LANES-1:0][WIDTH-1:0]  o_elems,
    output logic [7:0]                   o_scale,
    output logic                         o_first,
    output logic                         o_last
);

    localparam int BEATS = K / LANES;
    localparam int CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [8:0]    MAXQ      = 9'((1 << (WIDTH - 1)) - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] beat_cnt;
    logic [7:0]    e_max;
    logic          nan;
    logic [15:0]   buffer [BEATS][LANES];

    logic          in_fire;
    logic          out_fire;
    logic          last_beat;
    logic [7:0]    beat_emax;
    logic          beat_nan;
    logic [7:0]    emax_next;
    logic          nan_next;

    assign in_fire   = i_valid && o_ready;
    assign out_fire  = o_valid && i_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Shift the 1.7 magnitude right by s with round-to-nearest-even, saturate symmetrically, then apply sign.
    function automatic logic [WIDTH-1:0] quantise(input logic [15:0] val, input logic [7:0] sc);
        logic [7:0]       ex;
        logic [7:0]       mag;
        logic [9:0]       s;
        logic [23:0]      ext;
        logic             rnd;
        logic [8:0]       q;
        logic [WIDTH-1:0] res;
        ex  = val[14:7];
        mag = {(ex != 8'd0), val[6:0]};
        s   = {2'b00, sc} - {2'b00, ex} + 10'(9 - WIDTH);
        ext = {mag, 16'h0000} >> s[3:0];
        rnd = ext[15] && ((|ext[14:0]) || ext[16]);
        q   = {1'b0, ext[23:16]} + {8'h00, rnd};
        if (q > MAXQ) begin
            q = MAXQ;
        end
        res = WIDTH'(q);
        if (val[15]) begin
            res = -res;
        end
        if (s >= 10'd16 || sc == 8'hFF) begin
            res = '0;
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (in_fire && last_beat)  state_next = DRAIN;
            DRAIN:   if (out_fire && last_beat) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        o_ready = (state == FILL);
        o_valid = (state == DRAIN);
        o_first = o_valid && (beat_cnt == '0);
        o_last  = o_valid && last_beat;
    end

    // The first beat of a block restarts both the exponent maximum and the NaN flag.
    always_comb begin
        beat_emax = '0;
        beat_nan  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (i_bf16[l][14:7] > beat_emax) beat_emax = i_bf16[l][14:7];
            if (i_bf16[l][14:7] == 8'hFF)    beat_nan  = 1'b1;
        end
        emax_next = (beat_cnt == '0 || beat_emax > e_max) ? beat_emax : e_max;
        nan_next  = beat_nan || (nan && beat_cnt != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt <= '0;
        end else if (in_fire || out_fire) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_max   <= '0;
            nan     <= 1'b0;
            o_scale <= '0;
            for (int b = 0; b < BEATS; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    buffer[b][l] <= '0;
                end
            end
        end else if (in_fire) begin
            for (int l = 0; l < LANES; l++) begin
                buffer[beat_cnt][l] <= i_bf16[l];
            end
            e_max <= emax_next;
            nan   <= nan_next;
            if (last_beat) begin
                o_scale <= nan_next ? 8'hFF : emax_next;
            end
        end
    end

    always_comb begin
        o_elems = '0;
        for (int l = 0; l < LANES; l++) begin
            if (o_valid) begin
                o_elems[l] = quantise(buffer[beat_cnt][l], o_scale);
            end
        end
    end

endmodule

// File: tb/tb_mx_int_block_quantiser.sv
// Directed bench for mx_int_block_quantiser: an 8-bit/8-lane instance and a 4-bit/4-lane instance.
module tb_mx_int_block_quantiser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             v8, r8, ov8, ir8, f8, l8;
    logic [7:0][15:0] bf8;
    logic [7:0][7:0]  el8;
    logic [7:0]       sc8;

    logic             v4, r4, ov4, ir4, f4, l4;
    logic [3:0][15:0] bf4;
    logic [3:0][3:0]  el4;
    logic [7:0]       sc4;

    int check_count = 0;
    int fail_count  = 0;

    logic [15:0] blk [32];
    logic [63:0] want_beats [4];

    mx_int_block_quantiser #(.WIDTH(8), .K(32), .LANES(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(r8), .i_bf16(bf8),
        .o_valid(ov8), .i_ready(ir8), .o_elems(el8), .o_scale(sc8), .o_first(f8), .o_last(l8)
    );

    mx_int_block_quantiser #(.WIDTH(4), .K(32), .LANES(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(r4), .i_bf16(bf4),
        .o_valid(ov4), .i_ready(ir4), .o_elems(el4), .o_scale(sc4), .o_first(f4), .o_last(l4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fillBlk(input logic [15:0] v);
        for (int i = 0; i < 32; i++) blk[i] = v;
    endtask

    task automatic sendBeat8(input int b);
        int guard;
        v8 = 1'b1;
        for (int l = 0; l < 8; l++) bf8[l] = blk[b*8 + l];
        guard = 0;
        while (!r8 && guard < 20) begin
            step();
            guard++;
        end
        checkOutput("in_ready", 64'(r8), 64'd1);
        step();
        v8 = 1'b0;
    endtask

    task automatic applyStimulus(input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step();
            end
            sendBeat8(b);
        end
        checkOutput("latency_valid", 64'(ov8), 64'd1);
        checkOutput("drain_ready", 64'(r8), 64'd0);
    endtask

    task automatic checkBeat(input int b, input logic [7:0] want_scale);
        checkOutput($sformatf("elems_b%0d", b), 64'(el8), want_beats[b]);
        checkOutput("scale", 64'(sc8), 64'(want_scale));
        checkOutput($sformatf("first_last_b%0d", b), {62'd0, f8, l8}, {62'd0, (b == 0), (b == 3)});
        checkOutput("ready_in_drain", 64'(r8), 64'd0);
    endtask

    task automatic receiveBlock(input logic [7:0] want_scale, input bit stalls);
        int guard;
        for (int b = 0; b < 4; b++) begin
            guard = 0;
            while (!ov8 && guard < 20) begin
                step();
                guard++;
            end
            checkOutput("out_valid", 64'(ov8), 64'd1);
            if (stalls) begin
                repeat ($urandom_range(1, 3)) begin
                    ir8 = 1'b0;
                    step();
                    checkBeat(b, want_scale);
                end
            end
            ir8 = 1'b1;
            checkBeat(b, want_scale);
            step();
            ir8 = 1'b0;
        end
        checkOutput("refill_ready", 64'(r8), 64'd1);
        checkOutput("refill_valid", 64'(ov8), 64'd0);
    endtask

    task automatic setOrderBlock();
        logic [15:0] pos [4];
        logic [15:0] neg [4];
        pos = '{16'h3F80, 16'h3F00, 16'h3E80, 16'h3E00};
        neg = '{16'hBF80, 16'hBF00, 16'hBE80, 16'hBE00};
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 8; l++) blk[b*8 + l] = l[0] ? neg[b] : pos[b];
        end
        want_beats = '{64'hC040C040C040C040, 64'hE020E020E020E020,
                       64'hF010F010F010F010, 64'hF808F808F808F808};
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        v8 = 1'b0; ir8 = 1'b0; bf8 = '0;
        v4 = 1'b0; ir4 = 1'b0; bf4 = '0;
        repeat (3) step();
        checkOutput("rst_valid", 64'(ov8), 64'd0);
        checkOutput("rst_ready", 64'(r8), 64'd1);
        checkOutput("rst_elems", 64'(el8), 64'd0);
        checkOutput("rst_scale", 64'(sc8), 64'd0);
        checkOutput("rst_first_last", {62'd0, f8, l8}, 64'd0);
        checkOutput("rst4_ready", 64'(r4), 64'd1);
        rst_n = 1'b1;
        step();

        $display("[TB] all ones");
        fillBlk(16'h3F80);
        want_beats = '{default: 64'h4040404040404040};
        applyStimulus(1'b0);
        receiveBlock(8'd127, 1'b0);

        $display("[TB] mixed values and subnormal flush");
        fillBlk(16'h0000);
        blk[0] = 16'h3FC0; blk[1] = 16'hBF80; blk[2] = 16'h3F00; blk[3] = 16'h0040;
        want_beats = '{64'h0000000000_20C060, 64'd0, 64'd0, 64'd0};
        applyStimulus(1'b0);
        receiveBlock(8'd127, 1'b0);

        $display("[TB] rounding and saturation");
        fillBlk(16'h3F80);
        blk[0] = 16'h3F81; blk[1] = 16'h3F83; blk[2] = 16'h3FFF; blk[3] = 16'hBFFF;
        want_beats = '{64'h40404040817F4240, 64'h4040404040404040,
                       64'h4040404040404040, 64'h4040404040404040};
        applyStimulus(1'b0);
        receiveBlock(8'd127, 1'b0);

        $display("[TB] large shared exponent");
        fillBlk(16'h0000);
        blk[0] = 16'h4780; blk[1] = 16'h3F80;
        want_beats = '{64'h0000000000000040, 64'd0, 64'd0, 64'd0};
        applyStimulus(1'b0);
        receiveBlock(8'd143, 1'b0);

        $display("[TB] NaN block");
        fillBlk(16'h3F80);
        blk[13] = 16'h7FC0;
        want_beats = '{default: 64'd0};
        applyStimulus(1'b0);
        receiveBlock(8'd255, 1'b0);

        $display("[TB] random gaps and stalls");
        setOrderBlock();
        applyStimulus(1'b1);
        receiveBlock(8'd127, 1'b1);

        $display("[TB] reset mid-fill");
        fillBlk(16'h4780);
        sendBeat8(0);
        sendBeat8(1);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_valid", 64'(ov8), 64'd0);
        checkOutput("midrst_ready", 64'(r8), 64'd1);
        checkOutput("midrst_scale", 64'(sc8), 64'd0);
        step();
        checkOutput("midrst_valid_hold", 64'(ov8), 64'd0);
        rst_n = 1'b1;
        step();
        setOrderBlock();
        applyStimulus(1'b0);
        receiveBlock(8'd127, 1'b0);

        $display("[TB] WIDTH=4 instance");
        for (int b = 0; b < 8; b++) begin
            v4 = 1'b1;
            bf4 = {4{16'h3F80}};
            guard = 0;
            while (!r4 && guard < 20) begin
                step();
                guard++;
            end
            checkOutput("in4_ready", 64'(r4), 64'd1);
            step();
            v4 = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            guard = 0;
            while (!ov4 && guard < 20) begin
                step();
                guard++;
            end
            ir4 = 1'b1;
            checkOutput($sformatf("elems4_b%0d", b), 64'(el4), 64'h4444);
            checkOutput("scale4", 64'(sc4), 64'd127);
            checkOutput($sformatf("first_last4_b%0d", b), {62'd0, f4, l4}, {62'd0, (b == 0), (b == 7)});
            step();
            ir4 = 1'b0;
        end
        checkOutput("refill4_ready", 64'(r4), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
